// File: rtl/ioctl_upload_reader_pkg.sv
// Shared types and constants for the data_io upload readback path.
package ioctl_upload_reader_pkg;

  localparam int unsigned AW_DEFAULT = 23;
  localparam int unsigned DW         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SERVE = 2'd3
  } state_t;

  // Pick the byte lane of a 16-bit word: hi=0 -> [7:0], hi=1 -> [15:8].
  function automatic logic [7:0] byte_sel(input logic [DW-1:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/ioctl_upload_reader_toggle_req_master.sv
// Toggle req/ack client: one outstanding word read at a time.
module toggle_req_master
  import ioctl_upload_reader_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] addr,
  input  logic          port_ack,
  input  logic [DW-1:0] port_q,
  output logic          port_req,
  output logic [AW-1:0] port_a,
  output logic          done_c,
  output logic [DW-1:0] data_c
);

  logic outstanding;

  // Request completes in the cycle the ack catches up with the toggled req.
  assign done_c = outstanding && (port_ack == port_req);
  assign data_c = port_q;

  // Reset resynchronises req to ack so no phantom request survives reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      port_req    <= port_ack;
      port_a      <= '0;
      outstanding <= 1'b0;
    end else if (start && !outstanding) begin
      port_req    <= ~port_req;
      port_a      <= addr;
      outstanding <= 1'b1;
    end else if (done_c) begin
      outstanding <= 1'b0;
    end
  end

endmodule

// File: rtl/ioctl_upload_reader.sv
// Byte readback for data_io uploads over an SDRAM word port, with a
// one-word cache and next-word prefetch after the odd byte is served.
module ioctl_upload_reader
  import ioctl_upload_reader_pkg::*;
#(
  parameter int unsigned BASE_WORD = 0,
  parameter int unsigned AW        = AW_DEFAULT
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          busy,
  output logic          port_req,
  input  logic          port_ack,
  output logic [AW-1:0] port_a,
  output logic [1:0]    port_ds,
  output logic          port_we,
  input  logic [15:0]   port_q
);

  localparam logic [AW-1:0] BASE = AW'(BASE_WORD);

  state_t        state;
  logic          rd_d;
  logic          accept_c;
  logic [AW-1:0] acc_word_c;
  logic          hit_c;

  logic [DW-1:0] cache_q;
  logic [AW-1:0] cache_tag;
  logic          cache_valid;
  logic [AW-1:0] req_word;

  logic          rd_valid;
  logic [AW-1:0] rd_word;
  logic          rd_hi;
  logic          discard;

  logic          pend_valid_c;
  logic [AW-1:0] pend_word_c;

  logic          start_c;
  logic          done_c;
  logic [DW-1:0] data_c;

  logic          unused_addr;

  assign port_ds     = 2'b11;
  assign port_we     = 1'b0;
  assign unused_addr = ioctl_addr[24];

  // Read acceptance, word address (wraps modulo 2^AW) and cache hit.
  assign accept_c     = ioctl_rd && !rd_d && ioctl_upload;
  assign acc_word_c   = BASE + AW'(ioctl_addr[23:1]);
  assign hit_c        = cache_valid && (cache_tag == acc_word_c);
  assign pend_valid_c = accept_c || rd_valid;
  assign pend_word_c  = accept_c ? acc_word_c : rd_word;
  assign start_c      = (state == ISSUE) && ioctl_upload;

  // Rising-edge detector for the data_io read strobe.
  always_ff @(posedge clk_sys) begin
    if (reset) rd_d <= 1'b0;
    else       rd_d <= ioctl_rd;
  end

  toggle_req_master #(.AW(AW)) u_req (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (start_c),
    .addr     (req_word),
    .port_ack (port_ack),
    .port_q   (port_q),
    .port_req (port_req),
    .port_a   (port_a),
    .done_c   (done_c),
    .data_c   (data_c)
  );

  // Read/prefetch sequencer; while upload is low an in-flight ack is drained and dropped.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      ioctl_din   <= '0;
      busy        <= 1'b0;
      cache_q     <= '0;
      cache_tag   <= '0;
      cache_valid <= 1'b0;
      req_word    <= '0;
      rd_valid    <= 1'b0;
      rd_word     <= '0;
      rd_hi       <= 1'b0;
      discard     <= 1'b0;
    end else if (!ioctl_upload) begin
      cache_valid <= 1'b0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      if (state == WAIT && !done_c) begin
        discard <= 1'b1;
      end else begin
        discard <= 1'b0;
        state   <= IDLE;
      end
    end else begin
      if (accept_c) begin
        rd_valid <= 1'b1;
        rd_word  <= acc_word_c;
        rd_hi    <= ioctl_addr[0];
        busy     <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept_c) begin
            if (hit_c) begin
              state <= SERVE;
            end else begin
              req_word <= acc_word_c;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done_c) begin
            discard <= 1'b0;
            if (!discard) begin
              cache_q     <= data_c;
              cache_tag   <= req_word;
              cache_valid <= 1'b1;
            end
            if (!pend_valid_c) begin
              state <= IDLE;
            end else if (!discard && pend_word_c == req_word) begin
              state <= SERVE;
            end else begin
              cache_valid <= 1'b0;
              req_word    <= pend_word_c;
              state       <= ISSUE;
            end
          end
        end
        SERVE: begin
          ioctl_din <= byte_sel(cache_q, rd_hi);
          if (!accept_c) begin
            busy     <= 1'b0;
            rd_valid <= 1'b0;
          end
          if (rd_hi) begin
            req_word <= rd_word + AW'(1);
            state    <= ISSUE;
          end else if (accept_c) begin
            if (hit_c) begin
              state <= SERVE;
            end else begin
              req_word <= acc_word_c;
              state    <= ISSUE;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
